mem_port_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port, variable-latency memory between the instruction-fetch path (read-only) and the data path (LDM/STM).
- Sits between the fetch unit, the data-memory stage driven by MemRead/MemWrite, and the physical memory.
- Sequences each access through a grant/issue/complete FSM, with fair alternation under contention and a timeout guard.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, variable-latency memory between the instruction
// fetch path (read-only) and the data path (LDM/STM).  Each access runs
// through IDLE -> BUSY_IF/BUSY_DM -> IDLE.  When both paths contend, the
// grant goes to the one that did not win last time.  A wait counter aborts
// an access that never sees mem_ready.
//
// Handshake (both requester ports): the requester raises req and holds its
// address/we/wdata stable until the matching valid pulse.  It must drop req
// in the cycle valid is high.  valid is a single-cycle pulse, and err
// qualifies it as a timed-out access.  The memory side sees mem_en held
// high with stable mem_addr/mem_we/mem_wdata until mem_ready.  mem_ready
// counts only while mem_en is high.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request and address
//   if_valid/if_rdata/if_err        fetch completion, data, timeout flag
//   dm_req/dm_we/dm_addr/dm_wdata   data request (read or write)
//   dm_valid/dm_rdata/dm_err        data completion, load data, timeout flag
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and request fields
//   mem_rdata/mem_ready             memory read data and completion
//   busy                            an access is in flight
//   owner                           current/most recent grantee (1 = data)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_owner_q;
    logic               owner_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [ADDR_W-1:0]  lat_addr_q;
    logic               lat_we_q;
    logic [DATA_W-1:0]  lat_wdata_q;
    logic               if_valid_q, if_err_q, dm_valid_q, dm_err_q;
    logic [DATA_W-1:0]  if_rdata_q, dm_rdata_q;

    logic               if_elig, dm_elig;
    logic               grant_if, grant_dm;
    logic               done, timeout;

    // A requester whose valid is high this cycle is finishing; masking it
    // keeps a not-yet-dropped req from winning a second grant.
    assign if_elig = if_req & ~if_valid_q;
    assign dm_elig = dm_req & ~dm_valid_q;

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_elig && dm_elig) begin
                    // Contention: the loser of the previous round wins.
                    if (last_owner_q) grant_if = 1'b1;
                    else              grant_dm = 1'b1;
                end else if (if_elig) begin
                    grant_if = 1'b1;
                end else if (dm_elig) begin
                    grant_dm = 1'b1;
                end
                if (grant_if)      state_d = BUSY_IF;
                else if (grant_dm) state_d = BUSY_DM;
            end
            BUSY_IF, BUSY_DM: begin
                // mem_ready in the final allowed cycle still counts as success.
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
            owner_q      <= 1'b0;
            wait_cnt_q   <= '0;
            lat_addr_q   <= '0;
            lat_we_q     <= 1'b0;
            lat_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_valid_q   <= 1'b0;
            dm_err_q     <= 1'b0;
            dm_rdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            dm_valid_q <= 1'b0;
            dm_err_q   <= 1'b0;

            if (grant_if) begin
                owner_q      <= 1'b0;
                last_owner_q <= 1'b0;
                wait_cnt_q   <= '0;
                lat_addr_q   <= if_addr;
                lat_we_q     <= 1'b0;
                lat_wdata_q  <= '0;
            end else if (grant_dm) begin
                owner_q      <= 1'b1;
                last_owner_q <= 1'b1;
                wait_cnt_q   <= '0;
                lat_addr_q   <= dm_addr;
                lat_we_q     <= dm_we;
                lat_wdata_q  <= dm_wdata;
            end

            if (state_q != IDLE && !done && !timeout) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            if (state_q == BUSY_IF && (done || timeout)) begin
                if_valid_q <= 1'b1;
                if_err_q   <= timeout;
                if_rdata_q <= timeout ? '0 : mem_rdata;
            end

            if (state_q == BUSY_DM && (done || timeout)) begin
                dm_valid_q <= 1'b1;
                dm_err_q   <= timeout;
                if (timeout)       dm_rdata_q <= '0;
                else if (!lat_we_q) dm_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = lat_we_q;
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;
    assign owner     = owner_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter.  Inputs change 1 ns after the rising
// edge, and outputs are sampled at that same point.  The memory is driven
// directly by the steps, so every expected value is written out by hand.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              owner;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_dm_rdata;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_valid (dm_valid),
        .dm_rdata (dm_rdata),
        .dm_err   (dm_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .owner    (owner)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        check("rst_mem_en",   32'(mem_en),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_owner",    32'(owner),    0);
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_dm_valid", 32'(dm_valid), 0);
        check("rst_if_rdata", 32'(if_rdata), 0);
        check("rst_dm_rdata", 32'(dm_rdata), 0);
        rst_n = 1'b1;
    endtask

    // Called in the first busy cycle of an access.  Checks the memory-side
    // fields each busy cycle, raises mem_ready after 'delay' extra cycles,
    // then checks the completion pulse and drops the finished requester's req.
    task automatic serve(input string tag, input logic exp_owner,
                         input logic [ADDR_W-1:0] exp_addr, input logic exp_we,
                         input logic [DATA_W-1:0] exp_wdata, input int delay,
                         input logic [DATA_W-1:0] rdata);
        for (int c = 0; c <= delay; c++) begin
            check({tag, "_mem_en"},   32'(mem_en),   1);
            check({tag, "_busy"},     32'(busy),     1);
            check({tag, "_owner"},    32'(owner),    32'(exp_owner));
            check({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
            check({tag, "_mem_we"},   32'(mem_we),   32'(exp_we));
            if (exp_we) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
            if (c == delay) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_ready = 1'b0;
        check({tag, "_done_mem_en"}, 32'(mem_en), 0);
        check({tag, "_done_busy"},   32'(busy),   0);
        if (exp_owner) begin
            if (!exp_we) exp_dm_rdata = rdata;
            check({tag, "_dm_valid"}, 32'(dm_valid), 1);
            check({tag, "_dm_err"},   32'(dm_err),   0);
            check({tag, "_dm_rdata"}, 32'(dm_rdata), 32'(exp_dm_rdata));
            check({tag, "_if_quiet"}, 32'(if_valid), 0);
            dm_req = 1'b0;
        end else begin
            exp_if_rdata = rdata;
            check({tag, "_if_valid"}, 32'(if_valid), 1);
            check({tag, "_if_err"},   32'(if_err),   0);
            check({tag, "_if_rdata"}, 32'(if_rdata), 32'(exp_if_rdata));
            check({tag, "_dm_quiet"}, 32'(dm_valid), 0);
            if_req = 1'b0;
        end
    endtask

    initial begin
        do_reset();

        // 1: fetch alone, mem_ready in cycle 3.
        if_req  = 1'b1;
        if_addr = 12'h010;
        tick();
        serve("t1", 1'b0, 12'h010, 1'b0, 8'h00, 2, 8'hA5);
        tick();
        check("t1_pulse_one_cycle", 32'(if_valid), 0);

        // mem_ready with mem_en low must not produce a completion.
        mem_ready = 1'b1;
        mem_rdata = 8'h11;
        tick();
        mem_ready = 1'b0;
        check("idle_ready_if_valid", 32'(if_valid), 0);
        check("idle_ready_dm_valid", 32'(dm_valid), 0);
        check("idle_ready_mem_en",   32'(mem_en),   0);

        // 2: contention right after reset goes to data, then alternates.
        do_reset();
        if_req  = 1'b1;
        if_addr = 12'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 12'h020;
        tick();
        serve("t2_dm", 1'b1, 12'h020, 1'b0, 8'h00, 0, 8'h5A);
        tick();
        serve("t2_if", 1'b0, 12'h100, 1'b0, 8'h00, 0, 8'h77);
        for (int p = 0; p < 4; p++) begin
            tick();
            if_req  = 1'b1;
            if_addr = 12'h200 + 12'(p);
            dm_req  = 1'b1;
            dm_addr = 12'h300 + 12'(p);
            tick();
            serve("t2_pair_dm", 1'b1, 12'h300 + 12'(p), 1'b0, 8'h00, p, 8'h40 + 8'(p));
            tick();
            serve("t2_pair_if", 1'b0, 12'h200 + 12'(p), 1'b0, 8'h00, 1, 8'h80 + 8'(p));
        end
        tick();

        // 3: store; requester fields change after grant and must be ignored.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 12'h0FF;
        dm_wdata = 8'h3C;
        tick();
        dm_wdata = 8'h00;
        dm_addr  = 12'h001;
        dm_we    = 1'b0;
        serve("t3", 1'b1, 12'h0FF, 1'b1, 8'h3C, 2, 8'hEE);
        tick();

        // Contention after a data grant goes to fetch.
        if_req  = 1'b1;
        if_addr = 12'h050;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 12'h060;
        tick();
        serve("alt_if", 1'b0, 12'h050, 1'b0, 8'h00, 0, 8'h12);
        tick();
        serve("alt_dm", 1'b1, 12'h060, 1'b0, 8'h00, 0, 8'h34);
        tick();

        // 4: timeout with a fetch pending.
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 12'h0AB;
        tick();
        if_req  = 1'b1;
        if_addr = 12'h0C0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            check("t4_mem_en", 32'(mem_en), 1);
            check("t4_owner",  32'(owner),  1);
            tick();
        end
        exp_dm_rdata = 8'h00;
        check("t4_mem_en_off", 32'(mem_en),   0);
        check("t4_dm_valid",   32'(dm_valid), 1);
        check("t4_dm_err",     32'(dm_err),   1);
        check("t4_dm_rdata",   32'(dm_rdata), 32'(exp_dm_rdata));
        dm_req = 1'b0;
        tick();
        check("t4_dm_valid_off", 32'(dm_valid), 0);
        check("t4_dm_err_off",   32'(dm_err),   0);
        serve("t4_if", 1'b0, 12'h0C0, 1'b0, 8'h00, 0, 8'h21);
        tick();

        // 5: mem_ready in the final allowed busy cycle.
        if_req  = 1'b1;
        if_addr = 12'h0CD;
        tick();
        serve("t5", 1'b0, 12'h0CD, 1'b0, 8'h00, TIMEOUT - 1, 8'h99);
        tick();

        // 6: reset during a fetch access, then a clean retry.
        if_req  = 1'b1;
        if_addr = 12'h0EE;
        tick();
        tick();
        check("t6_busy_before", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_mem_en",   32'(mem_en),   0);
        check("t6_async_busy",     32'(busy),     0);
        check("t6_async_owner",    32'(owner),    0);
        check("t6_async_if_valid", 32'(if_valid), 0);
        exp_if_rdata = '0;
        tick();
        rst_n = 1'b1;
        check("t6_no_pulse", 32'(if_valid), 0);
        check("t6_if_rdata", 32'(if_rdata), 0);
        tick();
        serve("t6", 1'b0, 12'h0EE, 1'b0, 8'h00, 1, 8'h6B);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
